// File: rtl/cg_pkg.sv
// ============================================================================
// Module   : cg_pkg
// Brief    : Types and constants shared by the photo-gate conditioner and core
// Revision : 1.0
// ============================================================================
`default_nettype none

package cg_pkg;

    localparam int CNT_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        TIMING = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cg_gate_filter.sv
// ============================================================================
// Module   : cg_gate_filter
// Brief    : Raw gate synchroniser, glitch filter and rise/fall pulse generator
// Revision : 1.0
// ============================================================================
`default_nettype none

module cg_gate_filter #(
    parameter int FLT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             I_RST,
    input  logic             I_RAW,
    input  logic [FLT_W-1:0] I_FLT,
    output logic             O_GATE,
    output logic             O_RISE,
    output logic             O_FALL
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FLT_W-1:0]       r_fcnt;
    logic                   r_gate;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_diff;
    logic                   w_take;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = (w_s != r_gate);
    // >= so that lowering I_FLT mid-count takes effect at once
    assign w_take = w_diff && (r_fcnt >= I_FLT);

    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_sync <= '0;
            r_fcnt <= '0;
            r_gate <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], I_RAW};
            if (w_take) begin
                r_gate <= w_s;
                r_fcnt <= '0;
            end else if (w_diff) begin
                r_fcnt <= r_fcnt + 1'b1;
            end else begin
                r_fcnt <= '0;
            end
            r_rise <= w_take && w_s;
            r_fall <= w_take && !w_s;
        end
    end

    assign O_GATE = r_gate;
    assign O_RISE = r_rise;
    assign O_FALL = r_fall;

endmodule

`default_nettype wire

// File: rtl/cg_gate_cond.sv
// ============================================================================
// Module   : cg_gate_cond
// Brief    : Photo-gate conditioner with beam-broken transit-time measurement
// Revision : 1.0
// ============================================================================
`default_nettype none

module cg_gate_cond
    import cg_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int FLT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             I_RST,
    input  logic             I_RAW,
    input  logic [FLT_W-1:0] I_FLT,
    input  logic             I_ARM,
    input  logic [CNT_W-1:0] I_TMO,
    output logic             O_GATE,
    output logic             O_RISE,
    output logic             O_FALL,
    output logic             O_BUSY,
    output logic             O_VLD,
    output logic [CNT_W-1:0] O_DUR,
    output logic             O_TMO,
    output logic             O_ERR
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_tcnt, w_tcnt_nxt;
    logic [CNT_W-1:0] r_dcnt, w_dcnt_nxt;
    logic [CNT_W-1:0] r_dur, w_dur_nxt;
    logic             r_vld, w_vld_nxt;
    logic             r_tmo, w_tmo_nxt;
    logic             r_err, w_err_nxt;
    logic             w_gate, w_rise, w_fall;
    logic [CNT_W-1:0] w_tcnt_inc;
    logic             w_tmo_hit;

    cg_gate_filter #(
        .FLT_W       (FLT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filter (
        .clk    (clk),
        .I_RST  (I_RST),
        .I_RAW  (I_RAW),
        .I_FLT  (I_FLT),
        .O_GATE (w_gate),
        .O_RISE (w_rise),
        .O_FALL (w_fall)
    );

    assign w_tcnt_inc = (r_tcnt == c_cnt_max) ? r_tcnt : r_tcnt + 1'b1;
    assign w_tmo_hit  = (I_TMO != '0) && (w_tcnt_inc == I_TMO);

    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_state <= IDLE;
            r_tcnt  <= '0;
            r_dcnt  <= '0;
            r_dur   <= '0;
            r_vld   <= 1'b0;
            r_tmo   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_dur   <= w_dur_nxt;
            r_vld   <= w_vld_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_dcnt_nxt  = r_dcnt;
        w_dur_nxt   = r_dur;
        w_vld_nxt   = 1'b0;
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (I_ARM) begin
                    if (w_gate) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_tmo_nxt   = 1'b0;
                        w_err_nxt   = 1'b0;
                        w_tcnt_nxt  = '0;
                        w_state_nxt = ARMED;
                    end
                end
            end
            ARMED: begin
                w_tcnt_nxt = w_tcnt_inc;
                if (w_rise) begin
                    w_dcnt_nxt  = CNT_W'(1);
                    w_state_nxt = TIMING;
                end else if (w_tmo_hit) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            TIMING: begin
                w_tcnt_nxt = w_tcnt_inc;
                // A completed measurement takes priority over a coincident timeout
                if (w_fall) begin
                    w_dur_nxt   = r_dcnt;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_tmo_hit) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_gate && (r_dcnt != c_cnt_max)) begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign O_GATE = w_gate;
    assign O_RISE = w_rise;
    assign O_FALL = w_fall;
    assign O_BUSY = (r_state != IDLE);
    assign O_VLD  = r_vld;
    assign O_DUR  = r_dur;
    assign O_TMO  = r_tmo;
    assign O_ERR  = r_err;

endmodule

`default_nettype wire
